// File: rtl/ins_mem_pkg.sv
// rtl/ins_mem_pkg.sv - shared types, constants and helpers for the instruction memory
package ins_mem_pkg;

  typedef enum logic {RUN, LOAD} ins_mem_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ins_mem_loader.sv
// rtl/ins_mem_loader.sv - byte-stream program loader: lane assembly, write pointer, LOAD/RUN FSM
module ins_mem_loader
  import ins_mem_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int MEMORY_DEPTH      = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic                              load_end,
  input  logic                              prog_valid,
  input  logic [7:0]                        prog_data,
  output logic                              prog_ready,
  output logic                              loading,
  output logic [$clog2(MEMORY_DEPTH):0]     load_count,
  output logic                              wr_en,
  output logic [$clog2(MEMORY_DEPTH)-1:0]   wr_addr,
  output logic [INSTRUCTION_WIDTH-1:0]      wr_data
);

  localparam int AW  = $clog2(MEMORY_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BPW = bytes_per_word(INSTRUCTION_WIDTH);
  localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

  ins_mem_state_t              state, state_n;
  logic [CW-1:0]               count_n;
  logic [LW-1:0]               lane, lane_n;
  logic [INSTRUCTION_WIDTH-1:0] word_buf, buf_n, merged;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      load_count <= '0;
      lane       <= '0;
      word_buf   <= '0;
    end else begin
      state      <= state_n;
      load_count <= count_n;
      lane       <= lane_n;
      word_buf   <= buf_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = load_count;
    lane_n  = lane;
    buf_n   = word_buf;
    wr_en   = 1'b0;
    wr_data = word_buf;
    merged  = word_buf;
    for (int i = 0; i < BPW; i++) begin
      if (lane == LW'(i)) merged[8*i +: 8] = prog_data;
    end

    case (state)
      RUN: begin
        if (load_start) begin
          state_n = LOAD;
          count_n = '0;
          lane_n  = '0;
          buf_n   = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          // restart discards any partially assembled word
          count_n = '0;
          lane_n  = '0;
          buf_n   = '0;
        end else begin
          if (prog_valid) begin
            if (lane == LW'(BPW - 1)) begin
              wr_en   = 1'b1;
              wr_data = merged;
              count_n = load_count + 1'b1;
              lane_n  = '0;
              buf_n   = '0;
            end else begin
              lane_n = lane + 1'b1;
              buf_n  = merged;
            end
          end
          // upper lanes of buf_n are still zero, giving the zero padding
          if (load_end) begin
            if (lane_n != '0) begin
              wr_en   = 1'b1;
              wr_data = buf_n;
              count_n = load_count + 1'b1;
              lane_n  = '0;
              buf_n   = '0;
            end
            state_n = RUN;
          end
          if (count_n == CW'(MEMORY_DEPTH)) state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign wr_addr    = load_count[AW-1:0];
  assign loading    = (state == LOAD);
  assign prog_ready = (state == LOAD);

endmodule

// File: rtl/ins_memory_sync.sv
// rtl/ins_memory_sync.sv - synchronous instruction memory with run-time byte loader
// Optional stored even parity per word when INS_MEM_PARITY_EN is defined.
module ins_memory_sync
  import ins_mem_pkg::*;
#(
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter int                           MEMORY_DEPTH      = 256,
  parameter int                           PC_WIDTH          = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = INSTRUCTION_WIDTH'(NOP_INSTR_DEFAULT),
  parameter string                        INIT_FILE         = "ins_mem_init.txt"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_req,
  input  logic [PC_WIDTH-1:0]             fetch_addr,
  output logic                            fetch_ready,
  output logic                            instr_valid,
  output logic [INSTRUCTION_WIDTH-1:0]    instruction,
  output logic                            addr_err,
`ifdef INS_MEM_PARITY_EN
  output logic                            parity_err,
`endif
  input  logic                            load_start,
  input  logic                            load_end,
  input  logic                            prog_valid,
  input  logic [7:0]                      prog_data,
  output logic                            prog_ready,
  output logic                            loading,
  output logic [$clog2(MEMORY_DEPTH):0]   load_count
);

  localparam int AW = $clog2(MEMORY_DEPTH);

  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic [INSTRUCTION_WIDTH-1:0] wr_data;
  logic [AW-1:0]                rd_addr;
  logic                         upper_err, fetch_err, accept;

  logic [INSTRUCTION_WIDTH-1:0] mem [MEMORY_DEPTH];
`ifdef INS_MEM_PARITY_EN
  logic                         par_mem [MEMORY_DEPTH];
`endif

  ins_mem_loader #(
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .MEMORY_DEPTH      (MEMORY_DEPTH)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_end   (load_end),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .loading    (loading),
    .load_count (load_count),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  generate
    if (PC_WIDTH > AW + 2) begin : g_upper
      assign upper_err = |fetch_addr[PC_WIDTH-1:AW+2];
    end else begin : g_no_upper
      assign upper_err = 1'b0;
    end
  endgenerate

  assign rd_addr     = fetch_addr[AW+1:2];
  assign fetch_err   = (fetch_addr[1:0] != 2'b00) || upper_err;
  assign fetch_ready = !loading;
  assign accept      = fetch_req && fetch_ready;

  // writes only happen in LOAD and reads only in RUN, so no read/write collision
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
`ifdef INS_MEM_PARITY_EN
      par_mem[wr_addr] <= ^wr_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
      instruction <= '0;
`ifdef INS_MEM_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      instr_valid <= accept;
      addr_err    <= accept && fetch_err;
`ifdef INS_MEM_PARITY_EN
      parity_err  <= accept && !fetch_err && ((^mem[rd_addr]) != par_mem[rd_addr]);
`endif
      if (accept) instruction <= fetch_err ? NOP_INSTR : mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_ins_memory_sync.sv
// tb/tb_ins_memory_sync.sv - scoreboard bench for ins_memory_sync
module tb_ins_memory_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        load_start = 1'b0;
  logic        load_end = 1'b0;
  logic        prog_valid = 1'b0;
  logic [7:0]  prog_data = '0;
  logic        fetch_ready, instr_valid, addr_err, prog_ready, loading, parity_err;
  logic [31:0] instruction;
  logic [8:0]  load_count;

  typedef struct packed {
    logic [31:0] ins;
    logic        aerr;
    logic        perr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

`ifndef INS_MEM_PARITY_EN
  assign parity_err = 1'b0;
`endif

  ins_memory_sync dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .addr_err    (addr_err),
`ifdef INS_MEM_PARITY_EN
    .parity_err  (parity_err),
`endif
    .load_start  (load_start),
    .load_end    (load_end),
    .prog_valid  (prog_valid),
    .prog_data   (prog_data),
    .prog_ready  (prog_ready),
    .loading     (loading),
    .load_count  (load_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got %h expected no response", instruction);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fetch_instr", instruction, e.ins);
        check("fetch_addr_err", {31'b0, addr_err}, {31'b0, e.aerr});
        check("fetch_parity_err", {31'b0, parity_err}, {31'b0, e.perr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ins, input logic ae, input logic pe);
    fetch_req  = 1'b1;
    fetch_addr = a;
    sb.push_back('{ins: ins, aerr: ae, perr: pe});
    tick();
  endtask

  task automatic idle();
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    prog_valid = 1'b1;
    prog_data  = b;
    tick();
    prog_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic end_load();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_addr_err", {31'b0, addr_err}, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_loading", {31'b0, loading}, 32'd0);
    check("rst_load_count", {23'b0, load_count}, 32'd0);
    check("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    check("rst_prog_ready", {31'b0, prog_ready}, 32'd0);
    check("rst_parity_err", {31'b0, parity_err}, 32'd0);
    rst = 1'b0;
    tick();

    // program image
    start_load();
    check("load_loading", {31'b0, loading}, 32'd1);
    check("load_prog_ready", {31'b0, prog_ready}, 32'd1);
    check("load_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    send_word(32'h0050_0093);
    send_word(32'h00A0_0113);
    send_word(32'h0020_8193);
    end_load();
    check("image_load_count", {23'b0, load_count}, 32'd3);
    check("image_loading", {31'b0, loading}, 32'd0);

    // T1 + T2
    fetch(32'h0, 32'h0050_0093, 1'b0, 1'b0);
    idle();
    fetch(32'h0, 32'h0050_0093, 1'b0, 1'b0);
    fetch(32'h4, 32'h00A0_0113, 1'b0, 1'b0);
    fetch(32'h8, 32'h0020_8193, 1'b0, 1'b0);
    idle();
    tick();
    tick();
    check("hold_valid_low", {31'b0, instr_valid}, 32'd0);
    check("hold_instruction", instruction, 32'h0020_8193);

    // T3
    fetch(32'h6, 32'h0000_0013, 1'b1, 1'b0);
    fetch(32'h400, 32'h0000_0013, 1'b1, 1'b0);
    fetch(32'h4, 32'h00A0_0113, 1'b0, 1'b0);
    idle();

    // T4
    start_load();
    send_word(32'h0010_0513);
    send_word(32'hDEAD_BEEF);
    end_load();
    check("t4_load_count", {23'b0, load_count}, 32'd2);
    fetch(32'h0, 32'h0010_0513, 1'b0, 1'b0);
    fetch(32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0);
    fetch(32'h8, 32'h0020_8193, 1'b0, 1'b0);
    idle();

    // T5
    start_load();
    send_byte(8'hAA);
    send_byte(8'hBB);
    prog_valid = 1'b1;
    prog_data  = 8'hCC;
    load_end   = 1'b1;
    tick();
    prog_valid = 1'b0;
    load_end   = 1'b0;
    check("t5_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    check("t5_load_count", {23'b0, load_count}, 32'd1);
    fetch(32'h0, 32'h00CC_BBAA, 1'b0, 1'b0);
    fetch(32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0);
    idle();

    end_load();
    check("end_in_run_loading", {31'b0, loading}, 32'd0);
    check("end_in_run_count", {23'b0, load_count}, 32'd1);

    // restart mid-word
    start_load();
    send_byte(8'h11);
    send_byte(8'h22);
    start_load();
    check("restart_count", {23'b0, load_count}, 32'd0);
    send_word(32'h1122_3344);
    end_load();
    check("restart_load_count", {23'b0, load_count}, 32'd1);
    fetch(32'h0, 32'h1122_3344, 1'b0, 1'b0);
    idle();

    // fetch in the load_start cycle returns pre-load contents, then reset mid-load
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    load_start = 1'b1;
    sb.push_back('{ins: 32'hDEAD_BEEF, aerr: 1'b0, perr: 1'b0});
    tick();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    check("start_fetch_loading", {31'b0, loading}, 32'd1);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_loading", {31'b0, loading}, 32'd0);
    check("midrst_count", {23'b0, load_count}, 32'd0);
    fetch(32'h0, 32'h1122_3344, 1'b0, 1'b0);
    idle();

    // fill the whole array: automatic return to RUN and saturation
    start_load();
    for (int i = 0; i < 256; i++) send_word(32'hA500_0000 | i);
    check("full_loading", {31'b0, loading}, 32'd0);
    check("full_load_count", {23'b0, load_count}, 32'd256);
    check("full_prog_ready", {31'b0, prog_ready}, 32'd0);
    send_byte(8'hFF);
    check("full_refused_count", {23'b0, load_count}, 32'd256);
    fetch(32'h3FC, 32'hA500_00FF, 1'b0, 1'b0);
    fetch(32'h0, 32'hA500_0000, 1'b0, 1'b0);
    fetch(32'h3FD, 32'h0000_0013, 1'b1, 1'b0);
    fetch(32'h200, 32'hA500_0080, 1'b0, 1'b0);
    idle();

`ifdef INS_MEM_PARITY_EN
    dut.par_mem[0] = ~dut.par_mem[0];
    fetch(32'h0, 32'hA500_0000, 1'b0, 1'b1);
    fetch(32'h4, 32'hA500_0001, 1'b0, 1'b0);
    idle();
`endif

    for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
